jtag_dr_bank: RTL and testbench
===============================

JTAG_DR_BANK -- requirements
Module: jtag_dr_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of each user register and of the data field.
REQ-002 SHALL have parameter ADDR_W, default 2: width of the address field.
REQ-003 SHALL have parameter NUM_REGS, default 4: number of user registers; legal range 1..2^ADDR_W.
REQ-004 SHALL have parameter RESET_VAL, default 0: reset value of every user register, DATA_W bits.
REQ-005 SHALL have port JTCK, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port JRSTN, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port JTDI, input, 1 bit: serial data in.
REQ-008 SHALL have port JSHIFT, input, 1 bit: Shift-DR state indicator.
REQ-009 SHALL have port JUPDATE, input, 1 bit: Update-DR state indicator.
REQ-010 SHALL have ports JCE1 and JCE2, input, 1 bit each: ER1 and ER2 chain enables (Capture/Shift-DR).
REQ-011 SHALL have port JRTI1, input, 1 bit: Run-Test-Idle with ER1 active.
REQ-012 SHALL have ports JTDO1 and JTDO2, output, 1 bit each: serial data out, ER1 and ER2 chains.
REQ-013 SHALL have port regs_flat, output, NUM_REGS*DATA_W bits: register i at bits [i*DATA_W +: DATA_W].
REQ-014 SHALL have port upd_strobe, output, 1 bit: one-cycle pulse per accepted write.
REQ-015 SHALL have port rti1_pulse, output, 1 bit: one-cycle pulse on JRTI1 rising edge.

Function
REQ-016 SHALL size the ER1 frame at FW = 1+ADDR_W+DATA_W bits: [DATA_W-1:0] data, [DATA_W+ADDR_W-1:DATA_W] addr, [FW-1] wr.
REQ-017 SHALL capture ER1 when JCE1=1 and JSHIFT=0: sr1 <= {0, last_addr, rd}; rd is the register at last_addr, or 0 when last_addr >= NUM_REGS.
REQ-018 SHALL shift ER1 when JCE1=1 and JSHIFT=1: sr1 <= {JTDI, sr1[FW-1:1]}, LSB first.
REQ-019 SHALL drive JTDO1 = sr1[0] combinationally.
REQ-020 SHALL set flag sel1 on any cycle with JCE1=1 and clear it on the cycle JUPDATE=1.
REQ-021 SHALL on JUPDATE=1 with sel1=1: load last_addr <= sr1 addr field; if wr=1 and addr < NUM_REGS, write register[addr] <= data field and pulse upd_strobe on the next cycle.
REQ-022 SHALL ignore writes to out-of-range addresses: no register change, no upd_strobe, no upd_count increment; last_addr is still loaded.
REQ-023 SHALL ignore JUPDATE when sel1=0: no register, last_addr or sel1 change.
REQ-024 SHALL keep a 16-bit upd_count of accepted writes, wrapping 0xFFFF -> 0x0000.
REQ-025 SHALL implement ER2 as a 16-bit read-only chain: capture (JCE2=1, JSHIFT=0) loads sr2 <= upd_count; shift (JCE2=1, JSHIFT=1) does sr2 <= {JTDI, sr2[15:1]}; JTDO2 = sr2[0].
REQ-026 SHALL treat the ER1 and ER2 chains independently; if both enables are high, both chains act.
REQ-027 SHALL generate rti1_pulse = JRTI1 & ~jrti1_q, where jrti1_q is JRTI1 registered on JTCK.
REQ-028 SHALL register regs_flat directly from the register array, with no added latency beyond the write edge.

Reset
REQ-029 SHALL on JRSTN=0, asynchronously: registers <= RESET_VAL, sr1 <= 0, sr2 <= 0, last_addr <= 0, sel1 <= 0, upd_count <= 0, upd_strobe <= 0, jrti1_q <= 0.
REQ-030 SHALL on reset asserted mid-shift discard the partial frame; after release, no write occurs until a full capture/shift/update sequence completes.

Verification
REQ-031 SHALL check write: capture, shift 11 bits of frame wr=1 addr=2 data=0xA5, then JUPDATE -> regs_flat[23:16]=0xA5, one upd_strobe pulse, upd_count=1.
REQ-032 SHALL check readback: capture ER1 after REQ-031 and shift out 11 bits -> TDO sequence LSB first = 0xA5, then addr 2, then wr=0.
REQ-033 SHALL check out-of-range addressing: with NUM_REGS=3, write addr=3 data=0xFF -> no register change, no strobe, upd_count unchanged; next capture reads data 0x00, addr 3.
REQ-034 SHALL check unselected update: JUPDATE pulse with no JCE1 since the last update -> all state unchanged; ER2 capture/shift returns the upd_count value.
REQ-035 SHALL check mid-shift reset: JRSTN low after 5 shift bits -> all outputs 0; then a full write of 0x3C to addr 0 -> regs_flat[7:0]=0x3C.
REQ-036 SHALL check counter wrap and RTI: force 65536 accepted writes -> upd_count=0x0000; a JRTI1 0->1 transition -> exactly one rti1_pulse cycle.

Source files
------------

// File: rtl/jtag_dr_bank.sv
// User data-register bank behind two JTAG extended-register chains: ER1 reads/writes
// the register array through address/data frames, ER2 reads back the accepted-write count.
module jtag_dr_bank #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 2,
    parameter int                NUM_REGS  = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       JTCK,
    input  logic                       JRSTN,
    input  logic                       JTDI,
    input  logic                       JSHIFT,
    input  logic                       JUPDATE,
    input  logic                       JCE1,
    input  logic                       JCE2,
    input  logic                       JRTI1,
    output logic                       JTDO1,
    output logic                       JTDO2,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       upd_strobe,
    output logic                       rti1_pulse
);

    localparam int FW = 1 + ADDR_W + DATA_W;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [FW-1:0]     r_sr1;
    logic [15:0]       r_sr2;
    logic [15:0]       r_updCount;
    logic [ADDR_W-1:0] r_lastAddr;
    logic              r_sel1;
    logic              r_updStrobe;
    logic              r_jrti1Q;

    logic [DATA_W-1:0] w_rdData;
    logic [DATA_W-1:0] w_updData;
    logic [ADDR_W-1:0] w_updAddr;
    logic              w_updWr;
    logic              w_updInRange;
    logic              w_update;
    logic              w_acceptWrite;

    assign w_updData     = r_sr1[DATA_W-1:0];
    assign w_updAddr     = r_sr1[DATA_W+ADDR_W-1:DATA_W];
    assign w_updWr       = r_sr1[FW-1];
    assign w_updInRange  = (32'(w_updAddr) < NUM_REGS);
    assign w_update      = JUPDATE & r_sel1;
    assign w_acceptWrite = w_update & w_updWr & w_updInRange;

    // Read mux returns zero for an out-of-range last address.
    always_comb begin
        w_rdData = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_lastAddr == ADDR_W'(i)) begin
                w_rdData = r_regs[i];
            end
        end
    end

    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else if (w_acceptWrite) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_updAddr == ADDR_W'(i)) begin
                    r_regs[i] <= w_updData;
                end
            end
        end
    end

    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            r_sr1 <= '0;
        end else if (JCE1) begin
            if (JSHIFT) begin
                r_sr1 <= {JTDI, r_sr1[FW-1:1]};
            end else begin
                r_sr1 <= {1'b0, r_lastAddr, w_rdData};
            end
        end
    end

    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            r_sr2 <= '0;
        end else if (JCE2) begin
            if (JSHIFT) begin
                r_sr2 <= {JTDI, r_sr2[15:1]};
            end else begin
                r_sr2 <= r_updCount;
            end
        end
    end

    // Selection set wins over clear, so an update overlapping chain activity re-arms ER1.
    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            r_sel1 <= 1'b0;
        end else if (JCE1) begin
            r_sel1 <= 1'b1;
        end else if (JUPDATE) begin
            r_sel1 <= 1'b0;
        end
    end

    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            r_lastAddr  <= '0;
            r_updStrobe <= 1'b0;
            r_updCount  <= '0;
            r_jrti1Q    <= 1'b0;
        end else begin
            r_updStrobe <= w_acceptWrite;
            r_jrti1Q    <= JRTI1;
            if (w_update) begin
                r_lastAddr <= w_updAddr;
            end
            if (w_acceptWrite) begin
                r_updCount <= r_updCount + 16'd1;
            end
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = r_regs[i];
        end
    end

    assign JTDO1      = r_sr1[0];
    assign JTDO2      = r_sr2[0];
    assign upd_strobe = r_updStrobe;
    assign rti1_pulse = JRTI1 & ~r_jrti1Q;

endmodule

// File: tb/tb_jtag_dr_bank.sv
// Directed plus randomized bench for jtag_dr_bank: instance A (3 registers) for the register
// protocol against a frame-level model, instance B (4 registers) for the 16-bit counter wrap.
module tb_jtag_dr_bank;

    logic        JTCK = 1'b0;
    logic        JRSTN;
    logic        JTDI, JSHIFT, JUPDATE, JCE1, JCE2, JRTI1;
    logic        aTdo1, aTdo2, aStrobe, aRti;
    logic [23:0] aRegs;

    logic        bTdi, bShift, bUpdate, bCe1, bCe2, bRtiIn;
    logic        bTdo1, bTdo2, bStrobe, bRti;
    logic [31:0] bRegs;

    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;

    // Reference model: register contents, last addressed register, accepted-write count.
    logic [7:0] regsM [3];
    int         lastAddrM;
    int         countM;

    always #5 JTCK = ~JTCK;

    jtag_dr_bank #(.DATA_W(8), .ADDR_W(2), .NUM_REGS(3), .RESET_VAL(8'h00)) dutA (
        .JTCK(JTCK), .JRSTN(JRSTN), .JTDI(JTDI), .JSHIFT(JSHIFT), .JUPDATE(JUPDATE),
        .JCE1(JCE1), .JCE2(JCE2), .JRTI1(JRTI1), .JTDO1(aTdo1), .JTDO2(aTdo2),
        .regs_flat(aRegs), .upd_strobe(aStrobe), .rti1_pulse(aRti)
    );

    jtag_dr_bank dutB (
        .JTCK(JTCK), .JRSTN(JRSTN), .JTDI(bTdi), .JSHIFT(bShift), .JUPDATE(bUpdate),
        .JCE1(bCe1), .JCE2(bCe2), .JRTI1(bRtiIn), .JTDO1(bTdo1), .JTDO2(bTdo2),
        .regs_flat(bRegs), .upd_strobe(bStrobe), .rti1_pulse(bRti)
    );

    task automatic tick();
        @(posedge JTCK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [23:0] modelFlat();
        return {regsM[2], regsM[1], regsM[0]};
    endfunction

    function automatic logic [10:0] modelCapture();
        logic [7:0] rd;
        rd = 8'h00;
        if (lastAddrM < 3) rd = regsM[lastAddrM];
        return {1'b0, 2'(lastAddrM), rd};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 3; i++) regsM[i] = 8'h00;
        lastAddrM = 0;
        countM    = 0;
    endtask

    // Capture, shift one full frame in LSB first while collecting TDO, then Update-DR.
    task automatic applyStimulus(input logic [10:0] frame, output logic [10:0] captured,
                                 output logic strobeNow, output logic strobeNext);
        JCE1 = 1'b1; JSHIFT = 1'b0;
        tick();
        JSHIFT = 1'b1;
        for (int i = 0; i < 11; i++) begin
            captured[i] = aTdo1;
            JTDI = frame[i];
            tick();
        end
        JCE1 = 1'b0; JSHIFT = 1'b0; JTDI = 1'b0; JUPDATE = 1'b1;
        tick();
        strobeNow = aStrobe;
        JUPDATE = 1'b0;
        tick();
        strobeNext = aStrobe;
    endtask

    task automatic readEr2A(output logic [15:0] value);
        JCE2 = 1'b1; JSHIFT = 1'b0;
        tick();
        JSHIFT = 1'b1;
        for (int i = 0; i < 16; i++) begin
            value[i] = aTdo2;
            tick();
        end
        JCE2 = 1'b0; JSHIFT = 1'b0;
    endtask

    task automatic readEr2B(output logic [15:0] value);
        bCe2 = 1'b1; bShift = 1'b0;
        tick();
        bShift = 1'b1;
        for (int i = 0; i < 16; i++) begin
            value[i] = bTdo2;
            tick();
        end
        bCe2 = 1'b0; bShift = 1'b0;
    endtask

    // One ER1 transaction on instance A, checked against the model.
    task automatic runTxn(input logic wr, input logic [1:0] addr, input logic [7:0] data,
                          input string tag, output logic [10:0] captured);
        logic        sNow, sNext, accepted;
        logic [10:0] expCapt;
        logic [15:0] cnt;
        expCapt = modelCapture();
        applyStimulus({wr, addr, data}, captured, sNow, sNext);
        accepted  = wr && (addr < 2'd3);
        lastAddrM = int'(addr);
        if (accepted) begin
            regsM[addr] = data;
            countM      = (countM + 1) % 65536;
        end
        checkOutput({tag, "_capture"}, 32'(captured), 32'(expCapt));
        checkOutput({tag, "_regs"}, 32'(aRegs), 32'(modelFlat()));
        checkOutput({tag, "_strobe"}, 32'(sNow), 32'(accepted));
        checkOutput({tag, "_strobeEnd"}, 32'(sNext), 32'd0);
        readEr2A(cnt);
        checkOutput({tag, "_count"}, 32'(cnt), 32'(countM));
    endtask

    initial begin
        logic [10:0] capt;
        logic [15:0] cnt;
        logic        rw;
        logic [1:0]  ra;
        logic [7:0]  rdat;

        JRSTN = 1'b0; JTDI = 1'b0; JSHIFT = 1'b0; JUPDATE = 1'b0;
        JCE1 = 1'b0; JCE2 = 1'b0; JRTI1 = 1'b0;
        bTdi = 1'b0; bShift = 1'b0; bUpdate = 1'b0; bCe1 = 1'b0; bCe2 = 1'b0; bRtiIn = 1'b0;
        modelReset();
        repeat (3) tick();

        checkOutput("reset_regsA", 32'(aRegs), 32'd0);
        checkOutput("reset_strobeA", 32'(aStrobe), 32'd0);
        checkOutput("reset_tdo1A", 32'(aTdo1), 32'd0);
        checkOutput("reset_tdo2A", 32'(aTdo2), 32'd0);
        checkOutput("reset_rtiA", 32'(aRti), 32'd0);
        checkOutput("reset_regsB", bRegs, 32'd0);
        checkOutput("reset_tdoB", 32'({bTdo1, bTdo2, bRti}), 32'd0);

        JRSTN = 1'b1;
        tick();

        runTxn(1'b1, 2'd2, 8'hA5, "write", capt);
        checkOutput("write_reg2", 32'(aRegs[23:16]), 32'h0000_00A5);

        runTxn(1'b0, 2'd2, 8'h00, "readback", capt);
        checkOutput("readback_frame", 32'(capt), 32'h0000_02A5);

        runTxn(1'b1, 2'd3, 8'hFF, "oor", capt);
        runTxn(1'b1, 2'd1, 8'h5A, "afterOor", capt);
        checkOutput("oor_frame", 32'(capt), 32'h0000_0300);

        // Bare update with no ER1 selection since the last one must be ignored.
        JUPDATE = 1'b1;
        tick();
        JUPDATE = 1'b0;
        checkOutput("unsel_strobe", 32'(aStrobe), 32'd0);
        tick();
        checkOutput("unsel_regs", 32'(aRegs), 32'(modelFlat()));
        readEr2A(cnt);
        checkOutput("unsel_count", 32'(cnt), 32'(countM));

        for (int n = 0; n < 24; n++) begin
            rw   = 1'($urandom_range(0, 1));
            ra   = 2'($urandom_range(0, 3));
            rdat = 8'($urandom);
            runTxn(rw, ra, rdat, "random", capt);
        end

        JCE1 = 1'b1; JSHIFT = 1'b0;
        tick();
        JSHIFT = 1'b1; JTDI = 1'b1;
        repeat (5) tick();
        JRSTN = 1'b0;
        #1;
        checkOutput("midreset_regs", 32'(aRegs), 32'd0);
        checkOutput("midreset_strobe", 32'(aStrobe), 32'd0);
        checkOutput("midreset_tdo", 32'({aTdo1, aTdo2, aRti}), 32'd0);
        JCE1 = 1'b0; JSHIFT = 1'b0; JTDI = 1'b0;
        tick();
        JRSTN = 1'b1;
        modelReset();
        tick();
        JUPDATE = 1'b1;
        tick();
        JUPDATE = 1'b0;
        checkOutput("postreset_noWrite", 32'(aStrobe), 32'd0);
        tick();
        runTxn(1'b1, 2'd0, 8'h3C, "postreset", capt);
        checkOutput("postreset_reg0", 32'(aRegs[7:0]), 32'h0000_003C);

        JRTI1 = 1'b1;
        #1;
        checkOutput("rti_rise", 32'(aRti), 32'd1);
        tick();
        checkOutput("rti_hold1", 32'(aRti), 32'd0);
        tick();
        checkOutput("rti_hold2", 32'(aRti), 32'd0);
        JRTI1 = 1'b0;
        tick();
        checkOutput("rti_fall", 32'(aRti), 32'd0);

        // An all-ones frame is stable under shifting ones, so every update cycle is a write to reg 3.
        bCe1 = 1'b1; bShift = 1'b0;
        tick();
        bShift = 1'b1; bTdi = 1'b1;
        repeat (11) tick();
        bUpdate = 1'b1;
        repeat (65535) tick();
        bUpdate = 1'b0; bCe1 = 1'b0; bShift = 1'b0;
        checkOutput("wrap_strobe", 32'(bStrobe), 32'd1);
        checkOutput("wrap_reg3", 32'(bRegs[31:24]), 32'h0000_00FF);
        tick();
        readEr2B(cnt);
        checkOutput("wrap_countMax", 32'(cnt), 32'h0000_FFFF);
        bCe1 = 1'b1; bShift = 1'b1; bTdi = 1'b1; bUpdate = 1'b1;
        tick();
        bCe1 = 1'b0; bShift = 1'b0; bTdi = 1'b0; bUpdate = 1'b0;
        checkOutput("wrap_lastStrobe", 32'(bStrobe), 32'd1);
        tick();
        readEr2B(cnt);
        checkOutput("wrap_countZero", 32'(cnt), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
